// File: rtl/snow64_wb_write_queue_pkg.sv
// Shared types for the write-back queue: the decoded-instruction view seen from EX,
// queue entry layout, drain FSM states and the load/store type decoder.
package snow64_wb_write_queue_pkg;

   localparam int WB_ADDR_WIDTH  = 64;
   localparam int WB_DATA_WIDTH  = 64;
   localparam int WB_INDEX_WIDTH = 4;

   // LAR-file write types
   localparam logic [1:0] WriteTypOnlyData = 2'd0;
   localparam logic [1:0] WriteTypLd       = 2'd1;
   localparam logic [1:0] WriteTypSt       = 2'd2;

   // LAR data types
   localparam logic [1:0] DataTypUnsgnInt  = 2'd0;
   localparam logic [1:0] DataTypSgnInt    = 2'd1;
   localparam logic [1:0] DataTypBFloat16  = 2'd2;

   // Integer sizes
   localparam logic [1:0] IntTypSz8        = 2'd0;
   localparam logic [1:0] IntTypSz16       = 2'd1;
   localparam logic [1:0] IntTypSz32       = 2'd2;
   localparam logic [1:0] IntTypSz64       = 2'd3;

   // Group 2/3 opcodes (stores reuse the load numbering)
   localparam logic [3:0] OperLdU8  = 4'd0;
   localparam logic [3:0] OperLdS8  = 4'd1;
   localparam logic [3:0] OperLdU16 = 4'd2;
   localparam logic [3:0] OperLdS16 = 4'd3;
   localparam logic [3:0] OperLdU32 = 4'd4;
   localparam logic [3:0] OperLdS32 = 4'd5;
   localparam logic [3:0] OperLdU64 = 4'd6;
   localparam logic [3:0] OperLdS64 = 4'd7;
   localparam logic [3:0] OperLdF16 = 4'd8;

   // Group 0 opcode that never writes the LAR file
   localparam logic [3:0] OperSimSyscall = 4'hF;

   typedef struct packed {
      logic [2:0]                group;
      logic [3:0]                oper;
      logic [WB_INDEX_WIDTH-1:0] ra_index;
   } decoded_instr_t;

   typedef struct packed {
      logic [1:0]                write_type;
      logic [WB_INDEX_WIDTH-1:0] index;
      logic [WB_ADDR_WIDTH-1:0]  ldst_addr;
      logic [WB_DATA_WIDTH-1:0]  non_ldst_data;
      logic [1:0]                data_type;
      logic [1:0]                int_type_size;
   } wb_queue_entry_t;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StIssue = 2'd1,
      StWait  = 2'd2,
      StBad   = 2'd3
   } state_t;

   // Returns {data_type, int_type_size} for a load/store opcode.
   function automatic logic [3:0] decode_ldst_type(input logic [3:0] oper);
      logic [3:0] res;
      case (oper)
         OperLdU8:  res = {DataTypUnsgnInt, IntTypSz8};
         OperLdS8:  res = {DataTypSgnInt,   IntTypSz8};
         OperLdU16: res = {DataTypUnsgnInt, IntTypSz16};
         OperLdS16: res = {DataTypSgnInt,   IntTypSz16};
         OperLdU32: res = {DataTypUnsgnInt, IntTypSz32};
         OperLdS32: res = {DataTypSgnInt,   IntTypSz32};
         OperLdU64: res = {DataTypUnsgnInt, IntTypSz64};
         OperLdS64: res = {DataTypSgnInt,   IntTypSz64};
         OperLdF16: res = {DataTypBFloat16, IntTypSz16};
         default:   res = 4'd0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/snow64_wb_write_queue_if.sv
// EX-side enqueue signals and LAR-file write handshake of the write-back queue.
interface snow64_wb_write_queue_if #(parameter int DEPTH = 4);
   import snow64_wb_write_queue_pkg::*;

   logic                      in_valid;
   decoded_instr_t            in_decoded_instr;
   logic [WB_DATA_WIDTH-1:0]  in_computed_data;
   logic [WB_ADDR_WIDTH-1:0]  in_ldst_addr;
   logic                      out_stall;
   logic                      out_wr_req;
   logic [1:0]                out_wr_write_type;
   logic [WB_INDEX_WIDTH-1:0] out_wr_index;
   logic [WB_ADDR_WIDTH-1:0]  out_wr_ldst_addr;
   logic [WB_DATA_WIDTH-1:0]  out_wr_non_ldst_data;
   logic [1:0]                out_wr_data_type;
   logic [1:0]                out_wr_int_type_size;
   logic                      in_wr_valid;
   logic [$clog2(DEPTH):0]    out_count;

   // Environment side: EX and the LAR file
   modport master (
      output in_valid, in_decoded_instr, in_computed_data, in_ldst_addr, in_wr_valid,
      input  out_stall, out_wr_req, out_wr_write_type, out_wr_index, out_wr_ldst_addr,
             out_wr_non_ldst_data, out_wr_data_type, out_wr_int_type_size, out_count
   );

   // Queue side
   modport slave (
      input  in_valid, in_decoded_instr, in_computed_data, in_ldst_addr, in_wr_valid,
      output out_stall, out_wr_req, out_wr_write_type, out_wr_index, out_wr_ldst_addr,
             out_wr_non_ldst_data, out_wr_data_type, out_wr_int_type_size, out_count
   );
endinterface

// File: rtl/snow64_sync_fifo.sv
// Generic synchronous FIFO; pointers carry one extra wrap bit so full/empty
// and occupancy fall straight out of the pointer difference.
module snow64_sync_fifo #(
   parameter type T     = logic,
   parameter int  DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  T                       wdata,
   output T                       rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int IDX_W = $clog2(DEPTH);

   T                 mem [DEPTH];
   logic [IDX_W:0]   wr_ptr;
   logic [IDX_W:0]   rd_ptr;

   // Advance pointers on accepted push/pop; both may move in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop && !empty)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Entry storage is not reset; validity is tracked by the pointers alone.
   always_ff @(posedge clk) begin
      if (push && !full)
         mem[wr_ptr[IDX_W-1:0]] <= wdata;
   end

   assign rdata = mem[rd_ptr[IDX_W-1:0]];
   assign count = wr_ptr - rd_ptr;
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) && (wr_ptr[IDX_W] != rd_ptr[IDX_W]);
endmodule

// File: rtl/snow64_wb_write_queue.sv
// In-order write-back queue between EX and the LAR-file write port: buffers up
// to DEPTH writes and drains them one at a time over the req/valid handshake.
module snow64_wb_write_queue
   import snow64_wb_write_queue_pkg::*;
#(
   parameter int DEPTH       = 4,
   parameter int ADDR_WIDTH  = WB_ADDR_WIDTH,
   parameter int DATA_WIDTH  = WB_DATA_WIDTH,
   parameter int INDEX_WIDTH = WB_INDEX_WIDTH
) (
   input logic                   clk,
   input logic                   rst,
   snow64_wb_write_queue_if.slave bus
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   state_t              state;
   state_t              next_state;
   wb_queue_entry_t     enq_entry;
   wb_queue_entry_t     head;
   logic                enq_ok;
   logic                push;
   logic                pop;
   logic                full;
   logic                empty;
   logic [CNT_W-1:0]    fifo_count;
   logic [DATA_WIDTH-1:0]  enq_data;
   logic [ADDR_WIDTH-1:0]  enq_addr;
   logic [INDEX_WIDTH-1:0] enq_index;

   assign enq_data  = bus.in_computed_data;
   assign enq_addr  = bus.in_ldst_addr;
   assign enq_index = bus.in_decoded_instr.ra_index;

   // Classify the EX instruction and build the queue entry it would produce.
   always_comb begin
      enq_ok                  = 1'b0;
      enq_entry               = '0;
      enq_entry.index         = enq_index;
      case (bus.in_decoded_instr.group)
         3'd0: begin
            if (bus.in_decoded_instr.oper != OperSimSyscall) begin
               enq_ok                  = 1'b1;
               enq_entry.write_type    = WriteTypOnlyData;
               enq_entry.non_ldst_data = enq_data;
            end
         end
         3'd2: begin
            enq_ok                  = 1'b1;
            enq_entry.write_type    = WriteTypLd;
            enq_entry.ldst_addr     = enq_addr;
            {enq_entry.data_type, enq_entry.int_type_size} = decode_ldst_type(bus.in_decoded_instr.oper);
         end
         3'd3: begin
            enq_ok                  = 1'b1;
            enq_entry.write_type    = WriteTypSt;
            enq_entry.ldst_addr     = enq_addr;
            {enq_entry.data_type, enq_entry.int_type_size} = decode_ldst_type(bus.in_decoded_instr.oper);
         end
         default: enq_ok = 1'b0;
      endcase
   end

   assign push = bus.in_valid && !full && enq_ok;
   assign pop  = (state == StWait) && bus.in_wr_valid;

   snow64_sync_fifo #(
      .T     (wb_queue_entry_t),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata (enq_entry),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (fifo_count)
   );

   // Drain FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= StIdle;
      else
         state <= next_state;
   end

   // Drain FSM transitions; a same-cycle push keeps the queue non-empty after a pop.
   always_comb begin
      next_state = state;
      case (state)
         StIdle:  if (!empty) next_state = StIssue;
         StIssue: next_state = StWait;
         StWait: begin
            if (bus.in_wr_valid)
               next_state = ((fifo_count > CNT_W'(1)) || push) ? StIssue : StIdle;
         end
         default: next_state = StIdle;
      endcase
   end

   // Request pulse and head fields; fields read zero while idle.
   always_comb begin
      bus.out_wr_req           = (state == StIssue);
      bus.out_wr_write_type    = '0;
      bus.out_wr_index         = '0;
      bus.out_wr_ldst_addr     = '0;
      bus.out_wr_non_ldst_data = '0;
      bus.out_wr_data_type     = '0;
      bus.out_wr_int_type_size = '0;
      if ((state == StIssue) || (state == StWait)) begin
         bus.out_wr_write_type    = head.write_type;
         bus.out_wr_index         = head.index;
         bus.out_wr_ldst_addr     = head.ldst_addr;
         bus.out_wr_non_ldst_data = head.non_ldst_data;
         bus.out_wr_data_type     = head.data_type;
         bus.out_wr_int_type_size = head.int_type_size;
      end
   end

   // Stall only on the registered full flag so the path to IF/ID stays short.
   assign bus.out_stall = full;
   assign bus.out_count = fifo_count;
endmodule

// File: tb/tb_snow64_wb_write_queue.sv
// Directed bench for snow64_wb_write_queue (DEPTH=4).
module tb_snow64_wb_write_queue;
   import snow64_wb_write_queue_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk  = 0;
   int   n_pass = 0;
   int   n_req  = 0;
   logic [3:0] got_idx[$];

   snow64_wb_write_queue_if #(.DEPTH(4)) bus();

   snow64_wb_write_queue #(.DEPTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Request monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (bus.out_wr_req === 1'b1) begin
         n_req++;
         got_idx.push_back(bus.out_wr_index);
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp)
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] g, input logic [3:0] op, input logic [3:0] ra,
                        input logic [63:0] d, input logic [63:0] a);
      bus.in_valid                  = 1'b1;
      bus.in_decoded_instr.group    = g;
      bus.in_decoded_instr.oper     = op;
      bus.in_decoded_instr.ra_index = ra;
      bus.in_computed_data          = d;
      bus.in_ldst_addr              = a;
   endtask

   task automatic idle_in();
      bus.in_valid = 1'b0;
   endtask

   // Present one instruction until accepted, bounded.
   task automatic push_one(input string tag, input logic [3:0] ra);
      logic acc;
      acc = 1'b0;
      drive(3'd0, 4'd0, ra, 64'(ra), 64'd0);
      for (int i = 0; i < 40 && !acc; i++) begin
         acc = !bus.out_stall;
         step();
      end
      if (!acc) chk({tag, "_accept_timeout"}, 0, 1);
      idle_in();
   endtask

   task automatic wait_drain(input string tag);
      for (int i = 0; i < 100; i++) begin
         if (bus.out_count == 0) break;
         step();
      end
      chk(tag, bus.out_count, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0;
      bus.in_wr_valid = 1'b0;
      drive(3'd0, 4'd0, 4'd1, 64'h11, 64'd0);

      // 1: reset held with in_valid high
      step(); step(); step();
      chk("rst_req",   bus.out_wr_req, 0);
      chk("rst_stall", bus.out_stall,  0);
      chk("rst_count", bus.out_count,  0);
      idle_in();
      rst = 1'b0;
      step();

      // 2: single group-0 write
      drive(3'd0, 4'd0, 4'd3, 64'hDEAD, 64'd0);
      step();
      idle_in();
      chk("t2_count1", bus.out_count, 1);
      chk("t2_noreq",  bus.out_wr_req, 0);
      step();
      chk("t2_req",    bus.out_wr_req, 1);
      chk("t2_type",   bus.out_wr_write_type, WriteTypOnlyData);
      chk("t2_index",  bus.out_wr_index, 3);
      chk("t2_data",   bus.out_wr_non_ldst_data, 64'hDEAD);
      chk("t2_dtype",  bus.out_wr_data_type, 0);
      step();
      chk("t2_req_pulse", bus.out_wr_req, 0);
      chk("t2_hold_idx",  bus.out_wr_index, 3);
      bus.in_wr_valid = 1'b1;
      step();
      bus.in_wr_valid = 1'b0;
      chk("t2_count0", bus.out_count, 0);
      chk("t2_idle",   bus.out_wr_index, 0);

      // 3: LdS16 load, single pulse while valid withheld
      r0 = n_req;
      drive(3'd2, OperLdS16, 4'd5, 64'd0, 64'h1000);
      step();
      idle_in();
      step();
      chk("t3_req",   bus.out_wr_req, 1);
      chk("t3_type",  bus.out_wr_write_type, WriteTypLd);
      chk("t3_dtype", bus.out_wr_data_type, DataTypSgnInt);
      chk("t3_size",  bus.out_wr_int_type_size, IntTypSz16);
      chk("t3_addr",  bus.out_wr_ldst_addr, 64'h1000);
      chk("t3_index", bus.out_wr_index, 5);
      for (int i = 0; i < 10; i++) step();
      chk("t3_one_pulse", n_req - r0, 1);
      chk("t3_count", bus.out_count, 1);
      bus.in_wr_valid = 1'b1;
      step();
      bus.in_wr_valid = 1'b0;
      chk("t3_count0", bus.out_count, 0);

      // 3b: StF16 store, valid during StIssue is ignored
      drive(3'd3, OperLdF16, 4'd7, 64'd0, 64'hABC0);
      step();
      idle_in();
      step();
      chk("t3b_type",  bus.out_wr_write_type, WriteTypSt);
      chk("t3b_dtype", bus.out_wr_data_type, DataTypBFloat16);
      chk("t3b_size",  bus.out_wr_int_type_size, IntTypSz16);
      bus.in_wr_valid = 1'b1;
      step();
      chk("t3b_ignore_valid", bus.out_count, 1);
      step();
      bus.in_wr_valid = 1'b0;
      chk("t3b_count0", bus.out_count, 0);

      // 4: fill to full, fifth held, then drain in order
      got_idx.delete();
      for (int k = 1; k <= 4; k++) begin
         drive(3'd0, 4'd0, 4'(k), 64'(k), 64'd0);
         step();
      end
      idle_in();
      chk("t4_stall", bus.out_stall, 1);
      chk("t4_count", bus.out_count, 4);
      drive(3'd0, 4'd0, 4'd5, 64'd5, 64'd0);
      step(); step();
      chk("t4_held",       bus.out_count, 4);
      chk("t4_stall_held", bus.out_stall, 1);
      bus.in_wr_valid = 1'b1;
      push_one("t4", 4'd5);
      wait_drain("t4_drain");
      bus.in_wr_valid = 1'b0;
      chk("t4_nreq", got_idx.size(), 5);
      for (int k = 1; k <= 5 && k <= got_idx.size(); k++)
         chk($sformatf("t4_order%0d", k), got_idx[k-1], 64'(k));

      // 5: simultaneous enqueue/dequeue at count 3, then wrap
      got_idx.delete();
      for (int k = 1; k <= 3; k++) begin
         drive(3'd0, 4'd0, 4'(k), 64'(k), 64'd0);
         step();
      end
      idle_in();
      chk("t5_pre", bus.out_count, 3);
      drive(3'd0, 4'd0, 4'd4, 64'd4, 64'd0);
      bus.in_wr_valid = 1'b1;
      step();
      idle_in();
      chk("t5_simul",  bus.out_count, 3);
      chk("t5_nostall", bus.out_stall, 0);
      for (int k = 5; k <= 12; k++) push_one("t5", 4'(k));
      wait_drain("t5_drain");
      bus.in_wr_valid = 1'b0;
      chk("t5_nreq", got_idx.size(), 12);
      for (int k = 1; k <= 12 && k <= got_idx.size(); k++)
         chk($sformatf("t5_order%0d", k), got_idx[k-1], 64'(k));

      // 6: reset during StWait with 3 queued
      for (int k = 1; k <= 3; k++) begin
         drive(3'd0, 4'd0, 4'(k), 64'(k), 64'd0);
         step();
      end
      idle_in();
      chk("t6_pre", bus.out_count, 3);
      r0 = n_req;
      #2 rst = 1'b1;
      #1;
      chk("t6_async_count", bus.out_count, 0);
      step();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) step();
      chk("t6_no_req",  n_req - r0, 0);
      chk("t6_count0",  bus.out_count, 0);

      // SimSyscall and group 1 are dropped
      drive(3'd0, OperSimSyscall, 4'd9, 64'd1, 64'd0);
      step();
      drive(3'd1, 4'd0, 4'd10, 64'd2, 64'd0);
      step();
      idle_in();
      for (int i = 0; i < 5; i++) step();
      chk("t6_drop_count", bus.out_count, 0);
      chk("t6_drop_req",   n_req - r0, 0);

      // queue works again after reset
      drive(3'd0, 4'd0, 4'd6, 64'h66, 64'd0);
      step();
      idle_in();
      step();
      chk("t6_after_req", bus.out_wr_req, 1);
      chk("t6_after_idx", bus.out_wr_index, 6);
      step();
      bus.in_wr_valid = 1'b1;
      step();
      bus.in_wr_valid = 1'b0;
      chk("t6_after_count", bus.out_count, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
